// File: rtl/interconn_arb_if.sv
// interconn_arb_if: request/grant and crossbar-select bundle between MVU senders and the arbiter
interface interconn_arb_if #(
  parameter int N = 8,
  parameter int L = 8
);
  localparam int A = $clog2(N);
  logic [N-1:0]   req;
  logic [N*A-1:0] req_dst;
  logic [N*L-1:0] req_len;
  logic [N-1:0]   gnt;
  logic [N-1:0]   xfer_done;
  logic [N*A-1:0] recv_from;
  logic [N-1:0]   recv_busy;
  modport master (
    output req, req_dst, req_len,
    input  gnt, xfer_done, recv_from, recv_busy
  );
  modport slave (
    input  req, req_dst, req_len,
    output gnt, xfer_done, recv_from, recv_busy
  );
endinterface

// File: rtl/interconn_arb.sv
// interconn_arb: per-destination round-robin arbiter and burst sequencer for the MVU crossbar
module interconn_arb #(
  parameter int N = 8,
  parameter int L = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  interconn_arb_if.slave   bus
);
  localparam int A = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [A-1:0] LAST = A'(N - 1);
  logic [0:0]   state_q [N];
  logic [0:0]   state_d [N];
  logic [A-1:0] owner_q [N];
  logic [A-1:0] owner_d [N];
  logic [A-1:0] ptr_q   [N];
  logic [A-1:0] ptr_d   [N];
  logic [L-1:0] cnt_q   [N];
  logic [L-1:0] cnt_d   [N];
  // Outputs decoded purely from registers: each busy destination lights its owner's grant
  always_comb begin
    bus.gnt       = '0;
    bus.xfer_done = '0;
    bus.recv_busy = '0;
    bus.recv_from = '0;
    for (int j = 0; j < N; j++) begin
      bus.recv_from[j*A +: A] = owner_q[j];
      if (state_q[j] == BUSY) begin
        bus.gnt[owner_q[j]] = 1'b1;
        bus.recv_busy[j]    = 1'b1;
        if (cnt_q[j] == '0) bus.xfer_done[owner_q[j]] = 1'b1;
      end
    end
  end
  // Next state: rotating search from ptr for idle destinations, beat countdown for busy ones
  always_comb begin
    logic hit;
    int   pk;
    int   k;
    hit = 1'b0;
    pk  = 0;
    k   = 0;
    for (int j = 0; j < N; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
      if (state_q[j] == IDLE) begin
        hit = 1'b0;
        pk  = 0;
        for (int i = N - 1; i >= 0; i--) begin
          k = (int'(ptr_q[j]) + i) % N;
          if (bus.req[k] && int'(bus.req_dst[k*A +: A]) == j && !bus.gnt[k]) begin
            hit = 1'b1;
            pk  = k;
          end
        end
        if (hit) begin
          state_d[j] = BUSY;
          owner_d[j] = A'(pk);
          cnt_d[j]   = bus.req_len[pk*L +: L];
          ptr_d[j]   = (A'(pk) == LAST) ? '0 : A'(pk) + 1'b1;
        end
      end else if (cnt_q[j] == '0) begin
        state_d[j] = IDLE;
      end else begin
        cnt_d[j] = cnt_q[j] - 1'b1;
      end
    end
  end
  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
        cnt_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
    end
  end
endmodule

// File: tb/tb_interconn_arb.sv
// tb_interconn_arb: directed scenarios plus random traffic checked against a burst-level model
module tb_interconn_arb;
  localparam int N = 8;
  localparam int L = 8;
  localparam int A = 3;
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  int errors = 0;
  int checks = 0;
  interconn_arb_if #(.N(N), .L(L)) bus ();
  interconn_arb #(.N(N), .L(L)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
  always #5 clk = ~clk;
  // model: per destination whether a burst is running, who owns it, beats left, next start
  int m_busy [N];
  int m_own  [N];
  int m_left [N];
  int m_ptr  [N];
  logic [N-1:0] rq;
  int dst [N];
  int len [N];
  task automatic apply();
    bus.req = rq;
    for (int k = 0; k < N; k++) begin
      bus.req_dst[k*A +: A] = A'(dst[k]);
      bus.req_len[k*L +: L] = L'(len[k]);
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_busy[j] = 0; m_own[j] = 0; m_left[j] = 0; m_ptr[j] = 0;
    end
  endtask
  task automatic model_edge();
    bit held [N];
    for (int k = 0; k < N; k++) held[k] = 0;
    for (int j = 0; j < N; j++) if (m_busy[j] != 0) held[m_own[j]] = 1;
    for (int j = 0; j < N; j++) begin
      if (m_busy[j] != 0) begin
        m_left[j]--;
        if (m_left[j] == 0) m_busy[j] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr[j] + i) % N;
          if (rq[k] && dst[k] == j && !held[k]) begin
            m_busy[j] = 1; m_own[j] = k; m_left[j] = len[k] + 1; m_ptr[j] = (k + 1) % N;
            break;
          end
        end
      end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [N-1:0] eg, ex, eb;
    logic [N*A-1:0] ef;
    eg = '0; ex = '0; eb = '0; ef = '0;
    for (int j = 0; j < N; j++) begin
      ef[j*A +: A] = A'(m_own[j]);
      if (m_busy[j] != 0) begin
        eg[m_own[j]] = 1'b1;
        eb[j] = 1'b1;
        if (m_left[j] == 1) ex[m_own[j]] = 1'b1;
      end
    end
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("xfer_done", 32'(bus.xfer_done), 32'(ex));
    chk("recv_busy", 32'(bus.recv_busy), 32'(eb));
    chk("recv_from", 32'(bus.recv_from), 32'(ef));
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask
  task automatic set(input int k, input int d, input int l);
    rq[k] = 1'b1; dst[k] = d; len[k] = l;
  endtask
  initial begin
    rq = '0;
    for (int k = 0; k < N; k++) begin dst[k] = 0; len[k] = 0; end
    apply();
    #1 clr_n = 1'b0;
    model_reset();
    #2 check_all();
    @(negedge clk) clr_n = 1'b1;
    // single burst 2 -> 5, 4 beats
    set(2, 5, 3); apply(); cyc(1);
    rq = '0; apply(); cyc(6);
    // contention on dst 0, single-beat bursts
    set(1, 0, 0); set(3, 0, 0); set(6, 0, 0); apply(); cyc(12);
    rq = '0; apply(); cyc(3);
    // wrap-around: move ptr[4] to 7, then 0 and 7 compete
    set(6, 4, 0); apply(); cyc(1);
    rq = '0; apply(); cyc(2);
    set(0, 4, 1); set(7, 4, 1); apply(); cyc(7);
    rq = '0; apply(); cyc(3);
    // parallel grants to different destinations
    set(0, 4, 2); set(1, 5, 5); apply(); cyc(1);
    rq = '0; apply(); cyc(7);
    // destination change during a burst is ignored until it finishes
    set(3, 2, 7); apply(); cyc(2);
    dst[3] = 6; apply(); cyc(12);
    rq = '0; apply(); cyc(4);
    // asynchronous reset in the middle of a burst
    set(4, 1, 5); apply(); cyc(2);
    clr_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) clr_n = 1'b1;
    cyc(8);
    rq = '0; apply(); cyc(8);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) rq[k] = ~rq[k];
        if ($urandom_range(4) == 0) dst[k] = int'($urandom_range(N - 1));
        if ($urandom_range(4) == 0) len[k] = int'($urandom_range(4));
      end
      apply();
      cyc(1);
    end
    rq = '0; apply(); cyc(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/interconn_arb.md
# interconn_arb

Per-destination round-robin arbiter and burst sequencer for the MVU crossbar interconnect. Each MVU (sender) requests a burst to one destination MVU. The block resolves contention per destination, drives the crossbar's `recv_from` select lines, and grants each winning sender for exactly the requested number of beats. It sits beside the crossbar, between the MVU send controllers and the crossbar select inputs.

## Interface
- `N`, 8: number of MVUs; N ≥ 2.
- `L`, 8: width of the burst-length field.
- `A`, localparam $clog2(N): index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  bit k: sender k requests a burst.
- `req_dst`  in  N*A  field k: destination index of sender k.
- `req_len`  in  N*L  field k: burst beats minus one (0 means 1 beat).
- `gnt`  out  N  bit k: sender k may put a word on the crossbar this cycle.
- `xfer_done`  out  N  bit k: high during the last granted beat of sender k.
- `recv_from`  out  N*A  field j: crossbar source select for destination j.
- `recv_busy`  out  N  bit j: destination j is owned by a burst.

## Operation
- Each destination j runs an independent 2-state FSM: IDLE and BUSY. It holds registered `owner[j]` (A bits), `cnt[j]` (L bits) and `ptr[j]` (A bits, round-robin start).
- Sender k is eligible for destination j when `req[k]=1`, `req_dst[k]=j` and `gnt[k]=0`.
- IDLE with at least one eligible sender:
  - Choose the first eligible k, searching ptr[j], ptr[j]+1, … and wrapping modulo N.
  - Load owner[j]=k, recv_from[j]=k, cnt[j]=req_len[k], ptr[j]=(k+1) mod N.
  - Go to BUSY.
- IDLE with no eligible sender: stay in IDLE; recv_from[j] holds its last value.
- BUSY with cnt[j]>0: decrement cnt[j].
- BUSY with cnt[j]=0: go to IDLE.
- Output derivation:
  - `gnt[owner[j]]=1` while destination j is BUSY.
  - `xfer_done[owner[j]]=1` while BUSY and cnt[j]=0.
  - `recv_busy[j]` is 1 exactly when destination j is BUSY.
- req_dst and req_len are sampled only at the grant edge. Changes during a burst are ignored.
- Dropping req during a burst does not abort the burst; it runs to completion.
- A granted sender is excluded from all arbitration, so no sender is ever granted by two destinations.
- Senders with distinct destinations are granted in parallel, in the same cycle.
- `ptr` never advances without a grant.

## Timing
- Reset (clr_n=0, asynchronous):
  - All FSMs go to IDLE.
  - gnt=0, xfer_done=0, recv_busy=0.
  - recv_from=0, ptr=0, cnt=0, owner=0.
- Reset mid-burst aborts the burst immediately, with no xfer_done pulse.
- Operation resumes on the first rising edge after clr_n returns to 1.
- Grant latency: req seen at edge E while the destination is IDLE → gnt high from E to E+req_len+1, i.e. req_len+1 cycles.
- xfer_done coincides with the final gnt cycle.
- Release: the destination is IDLE for exactly one cycle after the last beat, then rearbitrates.
  - Back-to-back bursts to one destination therefore have a 1-cycle gap.
- Sender handshake:
  - A sender that wants no further burst drops req at the edge ending its xfer_done cycle.
  - If req is still high in the idle cycle, the sender is eligible again, subject to round-robin.
- All outputs are derived from registers only; there is no combinational path from inputs to outputs.
- The crossbar adds its own 1-cycle register. The word sent in grant cycle c appears at the destination in cycle c+1.

## Test plan
- Single burst: sender 2 requests dst 5, len 3 → after the next edge, gnt[2]=1 for 4 cycles; recv_from[5]=2; recv_busy[5]=1 for the same 4 cycles; xfer_done[2] high on the 4th; then one IDLE cycle.
- Contention: senders 1, 3 and 6 hold req to dst 0 with len 0 → grants in order 1, 3, 6, 1, 3, …, each 1 cycle, separated by 1 IDLE cycle.
- Wrap-around: ptr[4]=7; senders 0 and 7 request dst 4 → 7 granted; ptr[4] becomes 0; next grant goes to 0.
- Parallel: 0→4 (len 2) and 1→5 (len 5) requested in the same cycle → both granted at the same edge; gnt[0] lasts 3 cycles and gnt[1] lasts 6.
- Mid-burst changes: sender 3 changes req_dst from 2 to 6 during a len 7 burst to dst 2 → burst completes on dst 2 for 8 beats; dst 6 is not granted to 3 until after xfer_done.
- Reset mid-burst: clr_n pulled low during cycle 2 of a len 5 burst → gnt, recv_busy and recv_from are all 0 immediately with no xfer_done; after release, the held req is regranted with ptr=0 ordering.
